csr_encoder: RTL and testbench

- Writer-side counterpart of the HHT sparse-matrix fetch path.
- Consumes a dense N_ROWS x N_COLS matrix streamed row-major and writes it to memory in CSR form:
  - row pointers at row_base
  - column indices at col_base
  - nonzero values at val_base
- Output is the exact layout the HHT control block later reads through its address/data ports.
- Sits between a producer (host/DMA stream) and a single-port synchronous-write memory.

---
 rtl/csr_encoder.sv | 202 ++++++++++++++++++++
 tb/tb_csr_encoder.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_encoder.sv
// ---------------------------------------------------------------------------
// csr_encoder
//
// Purpose: writer-side counterpart of the HHT sparse-matrix fetch path.
// Consumes a dense N_ROWS x N_COLS matrix streamed row-major and writes it to
// a single-port synchronous-write memory in CSR form:
//   row pointers   (N_ROWS+1 words) at row_base
//   column indices (one per nonzero) at col_base
//   values         (one per nonzero) at val_base
//
// Optional feature: define CSR_THRESH_EN to add a `thresh` input; elements
// with in_data <= thresh (unsigned) are then dropped like zeros.
//
// Ports:
//   Clk, Rst               clock (rising edge), async active-high reset
//   start                  one-cycle pulse, honoured only in IDLE
//   row_base/col_base/val_base  array base addresses, latched on start
//   thresh                 drop threshold, latched on start (CSR_THRESH_EN)
//   in_valid/in_data/in_ready   dense element stream
//   WR/waddr/wdata         memory write port
//   busy, done             status; done is a one-cycle pulse
//   nnz_count              running / final nonzero count
//   dbg_state_o            current FSM state, for checkers
// ---------------------------------------------------------------------------
module csr_encoder #(
    parameter int N_ROWS = 16,
    parameter int N_COLS = 16,
    parameter int DW     = 32,
    parameter int AW     = 32
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          start,
    input  logic [AW-1:0] row_base,
    input  logic [AW-1:0] col_base,
    input  logic [AW-1:0] val_base,
`ifdef CSR_THRESH_EN
    input  logic [DW-1:0] thresh,
`endif
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          WR,
    output logic [AW-1:0] waddr,
    output logic [DW-1:0] wdata,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] nnz_count,
    output logic [2:0]    dbg_state_o
);

    localparam int RW = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
    localparam int CW = (N_COLS > 1) ? $clog2(N_COLS) : 1;
    localparam logic [RW-1:0] ROW_LAST = RW'(N_ROWS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(N_COLS - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PTR0    = 3'd1,
        S_ACCEPT  = 3'd2,
        S_WR_VAL  = 3'd3,
        S_WR_COL  = 3'd4,
        S_WR_RPTR = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    state_t        state_q;
    logic [AW-1:0] row_base_q, col_base_q, val_base_q;
    logic [RW-1:0] row_q;
    logic [CW-1:0] col_q;
    logic [DW-1:0] nnz_q;
    logic          wr_q, busy_q, done_q;
    logic [AW-1:0] waddr_q;
    logic [DW-1:0] wdata_q;
    logic          elem_zero;

`ifdef CSR_THRESH_EN
    logic [DW-1:0] thresh_q;
    assign elem_zero = (in_data <= thresh_q);
`else
    assign elem_zero = (in_data == '0);
`endif

    // Handshake: an element transfers on a rising edge where in_valid && in_ready.
    // in_ready depends only on state, so the producer never sees a combinational
    // path from in_valid back to in_ready; it must hold in_data while waiting.
    assign in_ready    = (state_q == S_ACCEPT);
    assign WR          = wr_q;
    assign waddr       = waddr_q;
    assign wdata       = wdata_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign nnz_count   = nnz_q;
    assign dbg_state_o = state_q;

    // Outputs are registered and loaded on the edge that enters a state, so the
    // write belonging to a state is on the bus for exactly that state's cycle.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q    <= S_IDLE;
            row_base_q <= '0;
            col_base_q <= '0;
            val_base_q <= '0;
`ifdef CSR_THRESH_EN
            thresh_q   <= '0;
`endif
            row_q      <= '0;
            col_q      <= '0;
            nnz_q      <= '0;
            wr_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
        end else begin
            wr_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        row_base_q <= row_base;
                        col_base_q <= col_base;
                        val_base_q <= val_base;
`ifdef CSR_THRESH_EN
                        thresh_q   <= thresh;
`endif
                        nnz_q      <= '0;
                        row_q      <= '0;
                        col_q      <= '0;
                        busy_q     <= 1'b1;
                        // Row pointer 0 is always 0.
                        wr_q       <= 1'b1;
                        waddr_q    <= row_base;
                        wdata_q    <= '0;
                        state_q    <= S_PTR0;
                    end
                end
                S_PTR0: begin
                    state_q <= S_ACCEPT;
                end
                S_ACCEPT: begin
                    if (in_valid) begin
                        if (!elem_zero) begin
                            wr_q    <= 1'b1;
                            waddr_q <= val_base_q + AW'(nnz_q);
                            wdata_q <= in_data;
                            state_q <= S_WR_VAL;
                        end else if (col_q != COL_LAST) begin
                            col_q <= col_q + CW'(1);
                        end else begin
                            // Dropped last element: close the row with the
                            // count as it stands.
                            wr_q    <= 1'b1;
                            waddr_q <= row_base_q + AW'(row_q) + AW'(1);
                            wdata_q <= nnz_q;
                            col_q   <= '0;
                            state_q <= S_WR_RPTR;
                        end
                    end
                end
                S_WR_VAL: begin
                    wr_q    <= 1'b1;
                    waddr_q <= col_base_q + AW'(nnz_q);
                    wdata_q <= DW'(col_q);
                    state_q <= S_WR_COL;
                end
                S_WR_COL: begin
                    nnz_q <= nnz_q + DW'(1);
                    if (col_q == COL_LAST) begin
                        // Pointer must include the nonzero just written.
                        wr_q    <= 1'b1;
                        waddr_q <= row_base_q + AW'(row_q) + AW'(1);
                        wdata_q <= nnz_q + DW'(1);
                        col_q   <= '0;
                        state_q <= S_WR_RPTR;
                    end else begin
                        col_q   <= col_q + CW'(1);
                        state_q <= S_ACCEPT;
                    end
                end
                S_WR_RPTR: begin
                    if (row_q == ROW_LAST) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        row_q   <= row_q + RW'(1);
                        state_q <= S_ACCEPT;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csr_encoder.sv
// ---------------------------------------------------------------------------
// tb_csr_encoder: directed test of csr_encoder with default parameters.
// A write monitor records every memory write into a sparse memory image and
// matches it, in order, against an expected write stream built from the
// dense test matrix. Hand-computed spot checks cover key addresses, counts
// and the all-zero latency.
// ---------------------------------------------------------------------------
module tb_csr_encoder;

    localparam int NR = 16;
    localparam int NC = 16;

    // ---------------- clock / reset ----------------
    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        start;
    logic [31:0] row_base, col_base, val_base;
`ifdef CSR_THRESH_EN
    logic [31:0] thresh;
`endif
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        WR;
    logic [31:0] waddr, wdata;
    logic        busy, done;
    logic [31:0] nnz_count;
    logic [2:0]  dbg_state;

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    csr_encoder #(.N_ROWS(NR), .N_COLS(NC), .DW(32), .AW(32)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .start      (start),
        .row_base   (row_base),
        .col_base   (col_base),
        .val_base   (val_base),
`ifdef CSR_THRESH_EN
        .thresh     (thresh),
`endif
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .WR         (WR),
        .waddr      (waddr),
        .wdata      (wdata),
        .busy       (busy),
        .done       (done),
        .nnz_count  (nnz_count),
        .dbg_state_o(dbg_state)
    );

    // ---------------- scoreboard ----------------
    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] exp_q[$];           // {waddr, wdata} in expected write order
    logic [31:0] mem [logic [31:0]];
    int          wr_cnt = 0;
    int          extra_wr = 0;
    logic [31:0] mat [NR][NC];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'hdeadbeef;
    endfunction

    function automatic bit dropped(input logic [31:0] v);
`ifdef CSR_THRESH_EN
        return v <= thresh;
`else
        return v == 32'd0;
`endif
    endfunction

    // Reference CSR layout of mat.
    function automatic void build_exp(input logic [31:0] rb, input logic [31:0] cb,
                                      input logic [31:0] vb);
        logic [31:0] n;
        n = 0;
        exp_q.push_back({rb, 32'd0});
        for (int r = 0; r < NR; r++) begin
            for (int c = 0; c < NC; c++) begin
                if (!dropped(mat[r][c])) begin
                    exp_q.push_back({vb + n, mat[r][c]});
                    exp_q.push_back({cb + n, 32'(c)});
                    n = n + 1;
                end
            end
            exp_q.push_back({rb + 32'(r) + 1, n});
        end
    endfunction

    // Write monitor, sampled mid-cycle.
    always @(negedge Clk) begin
        if (WR) begin
            mem[waddr] = wdata;
            wr_cnt++;
            check("rdy_low_during_wr", 64'(in_ready), 0);
            if (exp_q.size() > 0) check("wr", {waddr, wdata}, exp_q.pop_front());
            else extra_wr++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_mat();
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++) mat[r][c] = 32'd0;
    endtask

    task automatic row0_pattern();
        clear_mat();
        mat[0][3] = 27; mat[0][4] = 60; mat[0][6] = 77; mat[0][8] = 36; mat[0][9] = 96;
    endtask

    // Called at a negedge; returns at the negedge after the element transferred.
    task automatic send(input logic [31:0] v, input bit gaps);
        int t;
        if (gaps) begin
            while ($urandom_range(0, 1) == 1) begin
                in_valid = 1'b0;
                in_data  = $urandom();
                @(negedge Clk);
            end
        end
        in_valid = 1'b1;
        in_data  = v;
        t = 0;
        while (!in_ready && t < 16) begin
            @(negedge Clk);
            t++;
        end
        if (!in_ready) check("in_ready_timeout", 64'(in_ready), 1);
        @(negedge Clk);
        in_valid = 1'b0;
    endtask

    task automatic begin_enc(input logic [31:0] rb, input logic [31:0] cb, input logic [31:0] vb,
                             output int sc);
        exp_q.delete();
        mem.delete();
        extra_wr = 0;
        wr_cnt   = 0;
        build_exp(rb, cb, vb);
        row_base = rb; col_base = cb; val_base = vb;
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        sc = cyc;
        check("busy_after_start", 64'(busy), 1);
    endtask

    task automatic finish_enc(input int sc, output int lat);
        int t;
        t = 0;
        while (!done && t < 64) begin
            @(negedge Clk);
            t++;
        end
        check("done_seen", 64'(done), 1);
        lat = cyc - sc + 1;     // the start edge itself counts as cycle 1
        check("busy_at_done", 64'(busy), 0);
        @(negedge Clk);
        check("done_one_cycle", 64'(done), 0);
        check("missing_wr", 64'(exp_q.size()), 0);
        check("extra_wr", 64'(extra_wr), 0);
    endtask

    task automatic run(input logic [31:0] rb, input logic [31:0] cb, input logic [31:0] vb,
                       input bit gaps, input bit restart, output int lat);
        int sc;
        begin_enc(rb, cb, vb, sc);
        if (restart) begin
            // start pulses while busy must be ignored
            row_base = 32'h1000; col_base = 32'h2000; val_base = 32'h3000;
            start = 1'b1;
            repeat (2) @(negedge Clk);
            start = 1'b0;
        end
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++) send(mat[r][c], gaps);
        finish_enc(sc, lat);
    endtask

    // ---------------- main sequence ----------------
    int lat;
    int sc0;
    int wc;

    initial begin
        start = 1'b0; in_valid = 1'b0; in_data = '0;
        row_base = '0; col_base = '0; val_base = '0;
`ifdef CSR_THRESH_EN
        thresh = 32'd0;
`endif
        #2;
        check("rst_in_ready", 64'(in_ready), 0);
        check("rst_wr", 64'(WR), 0);
        check("rst_waddr", 64'(waddr), 0);
        check("rst_wdata", 64'(wdata), 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_done", 64'(done), 0);
        check("rst_nnz", 64'(nnz_count), 0);
        check("rst_state", 64'(dbg_state), 0);
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
        @(negedge Clk);

        // 1: all-zero matrix, in_valid held high
        clear_mat();
        run(23080, 2180, 90, 1'b0, 1'b0, lat);
        check("s1_latency", 64'(lat), 274);
        check("s1_nnz", 64'(nnz_count), 0);
        check("s1_wr_cnt", 64'(wr_cnt), 17);
        check("s1_ptr_last", 64'(rd(23096)), 0);

        // 2: diagonal (r,r) = r+1
        clear_mat();
        for (int r = 0; r < NR; r++) mat[r][r] = 32'(r + 1);
        run(23080, 2180, 90, 1'b0, 1'b0, lat);
        check("s2_nnz", 64'(nnz_count), 16);
        check("s2_wr_cnt", 64'(wr_cnt), 49);
        check("s2_val_first", 64'(rd(90)), 1);
        check("s2_val_last", 64'(rd(105)), 16);
        check("s2_col_last", 64'(rd(2195)), 15);
        check("s2_ptr1", 64'(rd(23081)), 1);
        check("s2_ptr_last", 64'(rd(23096)), 16);

        // 3: row 0 sparse, plus ignored start pulses while busy
        row0_pattern();
        run(23080, 2180, 90, 1'b0, 1'b1, lat);
        check("s3_nnz", 64'(nnz_count), 5);
        check("s3_wr_cnt", 64'(wr_cnt), 27);
        check("s3_val0", 64'(rd(90)), 27);
        check("s3_col0", 64'(rd(2180)), 3);
        check("s3_val4", 64'(rd(94)), 96);
        check("s3_col4", 64'(rd(2184)), 9);
        check("s3_ptr1", 64'(rd(23081)), 5);
        check("s3_ptr_last", 64'(rd(23096)), 5);

        // 4: same stimulus with random in_valid gaps
        run(23080, 2180, 90, 1'b1, 1'b0, lat);
        check("s4_nnz", 64'(nnz_count), 5);
        check("s4_val2", 64'(rd(92)), 77);
        check("s4_col3", 64'(rd(2183)), 8);
        check("s4_ptr_last", 64'(rd(23096)), 5);

        // 5: reset mid-row 5 of the diagonal, then a clean re-encode
        clear_mat();
        for (int r = 0; r < NR; r++) mat[r][r] = 32'(r + 1);
        begin_enc(23080, 2180, 90, sc0);
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < NC; c++) send(mat[r][c], 1'b0);
        for (int c = 0; c < 3; c++) send(mat[5][c], 1'b0);
        check("s5_nnz_before_abort", 64'(nnz_count), 5);
        exp_q.delete();
        wc = wr_cnt;
        #2 Rst = 1'b1;
        #1;
        check("s5_abort_wr", 64'(WR), 0);
        check("s5_abort_busy", 64'(busy), 0);
        check("s5_abort_nnz", 64'(nnz_count), 0);
        check("s5_abort_waddr", 64'(waddr), 0);
        check("s5_abort_rdy", 64'(in_ready), 0);
        repeat (2) @(negedge Clk);
        #2 Rst = 1'b0;
        @(negedge Clk);
        in_valid = 1'b1;
        in_data  = 32'd7;
        repeat (10) @(negedge Clk);
        in_valid = 1'b0;
        check("s5_no_wr_after_abort", 64'(wr_cnt), 64'(wc));
        check("s5_idle_rdy", 64'(in_ready), 0);
        run(23080, 2180, 90, 1'b0, 1'b0, lat);
        check("s5_nnz", 64'(nnz_count), 16);
        check("s5_ptr0", 64'(rd(23080)), 0);
        check("s5_ptr_last", 64'(rd(23096)), 16);

`ifdef CSR_THRESH_EN
        // 6: threshold drop, thresh = 30
        thresh = 32'd30;
        row0_pattern();
        run(23080, 2180, 90, 1'b0, 1'b0, lat);
        check("s6_nnz", 64'(nnz_count), 4);
        check("s6_ptr1", 64'(rd(23081)), 4);
        check("s6_val0", 64'(rd(90)), 60);
        check("s6_col0", 64'(rd(2180)), 4);
        check("s6_col3", 64'(rd(2183)), 9);
        thresh = 32'd0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
